// File: rtl/snail_match_counter.sv
// -----------------------------------------------------------------------------
// snail_match_counter
//
// Counts match pulses from the snail sequence detector over fixed windows of
// WIN enabled clock cycles. Each finished window's count is published through
// a one-entry valid/ready result register for the reporting logic.
//
// Parameters
//   CNT_W : width of the match count / result (count saturates at 2^CNT_W-1)
//   WIN   : window length in enabled cycles (>= 2)
//
// Ports
//   clk       in   system clock, all state changes on posedge
//   rst       in   synchronous active-high reset
//   en        in   count enable; when low, position/accumulator/edge history hold
//   q_in      in   detector match output, sampled at posedge
//   cnt_out   out  count of the most recently published window
//   cnt_valid out  result available
//   cnt_ready in   consumer accepts the result
//   ovf       out  sticky: a finished window was dropped (result register full)
//   run       out  high while the FSM is in RUN (also serves as state debug view)
//
// Handshake: cnt_out/cnt_valid form a valid/ready source. A transfer happens
// on a posedge where cnt_valid && cnt_ready. While cnt_valid=1, cnt_out is
// stable and cnt_valid only drops after a transfer. cnt_ready is ignored
// while cnt_valid=0. A window boundary coinciding with a transfer reloads the
// register and keeps cnt_valid high.
//
// Build option
//   SNAIL_CNT_EDGE_EN : when defined, a hit is a rising edge of q_in across
//                       enabled samples instead of a high level.
// -----------------------------------------------------------------------------
module snail_match_counter #(
  parameter int CNT_W = 8,
  parameter int WIN   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             q_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             ovf,
  output logic             run
);

  localparam int               POS_W    = $clog2(WIN);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_nxt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic [CNT_W-1:0] win_count;
  logic             hit;
  logic             boundary;
  logic             slot_free;
  logic             handshake;

  // ---------------------------------------------------------------------------
  // Hit detection
  // ---------------------------------------------------------------------------
`ifdef SNAIL_CNT_EDGE_EN
  // Previous enabled sample of q_in. It deliberately spans window boundaries
  // so a match that rises exactly at position 0 is still seen as an edge.
  logic q_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_prev <= 1'b0;
    end else if (en) begin
      q_prev <= q_in;
    end
  end

  assign hit = en & q_in & ~q_prev;
`else
  assign hit = en & q_in;
`endif

  // Count including this cycle's hit, saturating instead of wrapping.
  assign win_count = (acc == CNT_MAX) ? acc : (acc + CNT_W'(hit));

  assign boundary  = en && (pos == POS_LAST);
  assign handshake = cnt_valid && cnt_ready;
  assign slot_free = !cnt_valid || cnt_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, window position and accumulator
  // ---------------------------------------------------------------------------
  // The first enabled cycle in IDLE is already position 0 and is counted, so
  // the datapath below does not depend on the state; the state only records
  // whether a window is open. RUN is left only when enable drops while no
  // partial window is open.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    acc_nxt   = acc;

    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!en && (pos == '0)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (en) begin
      if (boundary) begin
        // The boundary hit belongs to the finishing window only.
        pos_nxt = '0;
        acc_nxt = '0;
      end else begin
        pos_nxt = pos + POS_W'(1);
        acc_nxt = win_count;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
      acc <= '0;
    end else begin
      pos <= pos_nxt;
      acc <= acc_nxt;
    end
  end

  assign run = (state == RUN);

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (boundary) begin
      if (slot_free) begin
        cnt_out   <= win_count;
        cnt_valid <= 1'b1;
      end else begin
        // Previous result still unread: drop this window, keep cnt_out.
        ovf <= 1'b1;
      end
    end else if (handshake) begin
      cnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snail_match_counter.sv
// -----------------------------------------------------------------------------
// tb_snail_match_counter
//
// Two instances share one stimulus stream: u0 (WIN=8, CNT_W=4) and u1
// (WIN=32, CNT_W=4, used to reach saturation inside one window). A reference
// model tracks, per instance, the number of enabled cycles into the current
// window and the raw number of hits, and derives the published count with
// plain arithmetic. Results accepted from u0 are checked against a queue of
// expected counts in publish order.
// -----------------------------------------------------------------------------
module tb_snail_match_counter;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

`ifdef SNAIL_CNT_EDGE_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk;
  logic             rst;
  logic             en;
  logic             q_in;
  logic             cnt_ready;
  logic [CNT_W-1:0] cnt_out0;
  logic             cnt_valid0;
  logic             ovf0;
  logic             run0;
  logic [CNT_W-1:0] cnt_out1;
  logic             cnt_valid1;
  logic             ovf1;
  logic             run1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  snail_match_counter #(.CNT_W(CNT_W), .WIN(8)) u0 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .q_in      (q_in),
    .cnt_out   (cnt_out0),
    .cnt_valid (cnt_valid0),
    .cnt_ready (cnt_ready),
    .ovf       (ovf0),
    .run       (run0)
  );

  snail_match_counter #(.CNT_W(CNT_W), .WIN(32)) u1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .q_in      (q_in),
    .cnt_out   (cnt_out1),
    .cnt_valid (cnt_valid1),
    .cnt_ready (cnt_ready),
    .ovf       (ovf1),
    .run       (run1)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         m_win   [2] = '{8, 32};
  int         m_seen  [2];   // enabled cycles into the current window
  int         m_hits  [2];   // raw hits in the current window (unsaturated)
  bit         m_valid [2];
  int         m_out   [2];
  bit         m_ovf   [2];
  bit         m_run   [2];
  bit         m_prev;        // last enabled q_in sample
  logic [CNT_W-1:0] exp_q[$];

  task automatic model_step(input bit r, input bit e, input bit qv, input bit rdy);
    bit hit;
    int cnt;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_seen[i]  = 0;
        m_hits[i]  = 0;
        m_valid[i] = 0;
        m_out[i]   = 0;
        m_ovf[i]   = 0;
        m_run[i]   = 0;
      end else begin
        hit = e && qv && (!EDGE_MODE || !m_prev);
        if (e) begin
          m_hits[i] += int'(hit);
          m_seen[i] += 1;
          if (m_seen[i] == m_win[i]) begin
            cnt = (m_hits[i] > SAT) ? SAT : m_hits[i];
            m_seen[i] = 0;
            m_hits[i] = 0;
            if (!m_valid[i] || rdy) begin
              m_out[i]   = cnt;
              m_valid[i] = 1;
              if (i == 0) exp_q.push_back(CNT_W'(cnt));
            end else begin
              m_ovf[i] = 1;
            end
          end else if (m_valid[i] && rdy) begin
            m_valid[i] = 0;
          end
        end else if (m_valid[i] && rdy) begin
          m_valid[i] = 0;
        end
        // Open window (or enabled this cycle) means RUN.
        m_run[i] = e || (m_seen[i] != 0);
      end
    end
    if (r) begin
      m_prev = 0;
      exp_q.delete();
    end else if (e) begin
      m_prev = qv;
    end
  endtask

  task automatic compare_all();
    check("u0_cnt_out",   32'(cnt_out0),   32'(m_out[0]));
    check("u0_cnt_valid", 32'(cnt_valid0), 32'(m_valid[0]));
    check("u0_ovf",       32'(ovf0),       32'(m_ovf[0]));
    check("u0_run",       32'(run0),       32'(m_run[0]));
    check("u1_cnt_out",   32'(cnt_out1),   32'(m_out[1]));
    check("u1_cnt_valid", 32'(cnt_valid1), 32'(m_valid[1]));
    check("u1_ovf",       32'(ovf1),       32'(m_ovf[1]));
    check("u1_run",       32'(run1),       32'(m_run[1]));
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Inputs change 3 ns after posedge, outputs are
  // compared 1 ns after the next posedge.
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit r, input bit e, input bit qv, input bit rdy);
    logic [CNT_W-1:0] exp_cnt;
    rst       = r;
    en        = e;
    q_in      = qv;
    cnt_ready = rdy;
    // A transfer will happen at the coming edge: check the accepted value.
    if (!r && (cnt_valid0 === 1'b1) && rdy) begin
      if (exp_q.size() == 0) begin
        check("xfer_unexpected", 32'(cnt_out0), 32'hFFFF_FFFF);
      end else begin
        exp_cnt = exp_q.pop_front();
        check("xfer_cnt", 32'(cnt_out0), 32'(exp_cnt));
      end
    end
    @(posedge clk);
    model_step(r, e, qv, rdy);
    #1;
    compare_all();
    #2;
  endtask

  task automatic run_pattern(input logic [7:0] pat, input bit rdy_first, input bit rdy_rest);
    // pat[7] is the first bit of the window.
    for (int k = 7; k >= 0; k--) begin
      cycle(1'b0, 1'b1, pat[k], (k == 7) ? rdy_first : rdy_rest);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    q_in      = 1'b0;
    cnt_ready = 1'b0;

    // Reset with en=1, q_in=1 asserted.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_cnt_out",   32'(cnt_out0),   32'd0);
    check("rst_cnt_valid", 32'(cnt_valid0), 32'd0);
    check("rst_ovf",       32'(ovf0),       32'd0);
    check("rst_run",       32'(run0),       32'd0);

    // Level pattern 1,1,0,1,0,0,1,1.
    run_pattern(8'b1101_0011, 1'b1, 1'b1);
    check("level_valid", 32'(cnt_valid0), 32'd1);
    check("level_cnt",   32'(cnt_out0),   EDGE_MODE ? 32'd3 : 32'd5);

    // A zero window: next window starts from 0, handshake drops valid.
    run_pattern(8'b0000_0000, 1'b1, 1'b1);
    check("zero_cnt", 32'(cnt_out0), 32'd0);

    // Edge pattern 1,1,1,0,1,1,0,0.
    run_pattern(8'b1110_1100, 1'b1, 1'b1);
    check("edge_pat_cnt", 32'(cnt_out0), EDGE_MODE ? 32'd2 : 32'd5);

    // Backpressure: drain, then hold ready low across two boundaries.
    run_pattern(8'b1111_1111, 1'b1, 1'b0);
    check("bp_first_valid", 32'(cnt_valid0), 32'd1);
    check("bp_first_cnt",   32'(cnt_out0),   EDGE_MODE ? 32'd1 : 32'd8);
    check("bp_first_ovf",   32'(ovf0),       32'd0);
    run_pattern(8'(($urandom_range(0, 255))), 1'b0, 1'b0);
    check("bp_drop_ovf", 32'(ovf0),       32'd1);
    check("bp_hold_cnt", 32'(cnt_out0),   EDGE_MODE ? 32'd1 : 32'd8);
    check("bp_hold_vld", 32'(cnt_valid0), 32'd1);
    // Ready only on the boundary cycle: accept + reload, valid stays high.
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, (k == 7));
    check("bp_reload_cnt", 32'(cnt_out0),   32'd0);
    check("bp_reload_vld", 32'(cnt_valid0), 32'd1);

    // Enable gap mid-window with q_in high.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check("gap_run", 32'(run0), 32'd1);
    end
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("gap_cnt", 32'(cnt_out0), EDGE_MODE ? 32'd1 : 32'd3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("gap_idle_run", 32'(run0),       32'd0);
    check("gap_idle_vld", 32'(cnt_valid0), 32'd0);

    // Saturation on the WIN=32 instance.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      if (k == 31) begin
        check("sat_valid", 32'(cnt_valid1), 32'd1);
        check("sat_cnt",   32'(cnt_out1),   EDGE_MODE ? 32'd1 : 32'(SAT));
      end
    end

    // Reset mid-window with a pending result.
    for (int k = 0; k < 11; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("midrst_vld", 32'(cnt_valid0), 32'd0);
    check("midrst_ovf", 32'(ovf0),       32'd0);
    check("midrst_cnt", 32'(cnt_out0),   32'd0);
    check("midrst_run", 32'(run0),       32'd0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
